// File: rtl/tqvp_wdt_pkg.sv
// tqvp_wdt_pkg: shared constants and helpers for the multi-channel watchdog.
// Register map offsets, global addresses, tap magic, write-size extension.
package tqvp_wdt_pkg;

   localparam logic [31:0] TAP_MAGIC   = 32'h0000_ABCD;
   localparam logic [31:0] RD_UNMAPPED = 32'hFFFF_FFFF;

   localparam logic [2:0] OFF_CTRL   = 3'd0;
   localparam logic [2:0] OFF_RELOAD = 3'd1;
   localparam logic [2:0] OFF_WINDOW = 3'd2;
   localparam logic [2:0] OFF_TAP    = 3'd3;
   localparam logic [2:0] OFF_STATUS = 3'd4;
   localparam logic [2:0] OFF_COUNT  = 3'd5;

   localparam logic [5:0] ADDR_PRESCALE   = 6'h20;
   localparam logic [5:0] ADDR_IRQ_STATUS = 6'h21;

   typedef enum logic [1:0] {
      SZ_8    = 2'b00,
      SZ_16   = 2'b01,
      SZ_32   = 2'b10,
      SZ_NONE = 2'b11
   } xfer_sz_e;

   function automatic logic [31:0] wr_extend(
      input logic [1:0]  sz,
      input logic [31:0] d
   );
      logic [31:0] r;
      unique case (xfer_sz_e'(sz))
         SZ_8:    r = {24'b0, d[7:0]};
         SZ_16:   r = {16'b0, d[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tqvp_nkanderson_wdt_mc_if.sv
// tqvp_nkanderson_wdt_mc_if: register bus between host and watchdog.
// Combinational read path; writes take effect on the clock edge.
interface tqvp_nkanderson_wdt_mc_if;

   logic [5:0]  address;
   logic [31:0] data_in;
   logic [1:0]  data_write_n;
   logic [1:0]  data_read_n;
   logic [31:0] data_out;
   logic        data_ready;

   modport master (
      output address,
      output data_in,
      output data_write_n,
      output data_read_n,
      input  data_out,
      input  data_ready
   );

   modport slave (
      input  address,
      input  data_in,
      input  data_write_n,
      input  data_read_n,
      output data_out,
      output data_ready
   );

endinterface

// File: rtl/tqvp_wdt_channel.sv
// tqvp_wdt_channel: one watchdog channel (counter, flags, tap, lock).
// The window check exists only when WDT_WINDOW_EN is defined.
module tqvp_wdt_channel #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             ctrl_we,
   input  logic             reload_we,
   input  logic             window_we,
   input  logic             tap_we,
   input  logic             tap_ok,
   input  logic [3:0]       ctrl_wdata,
   input  logic [CNT_W-1:0] wdata,
   output logic [3:0]       ctrl,
   output logic [CNT_W-1:0] reload,
   output logic [CNT_W-1:0] window,
   output logic [CNT_W-1:0] count,
   output logic [4:0]       status,
   output logic             pending,
   output logic             irq_en
);

   logic             enabled_q;
   logic             started_q;
   logic             irq_en_q;
   logic             lock_q;
   logic             pend_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] reload_q;

   logic             start_ok;
   logic             ctrl_ok;
   logic             tap_hit;
   logic             dec;
   logic             win_bad;
   logic             violation;

   // A start with a zero reload value discards the whole CTRL write.
   assign start_ok = ctrl_we && !lock_q && ctrl_wdata[1]
                     && (reload_q != '0);
   assign ctrl_ok  = ctrl_we && !lock_q
                     && !(ctrl_wdata[1] && (reload_q == '0));
   assign tap_hit  = tap_we && tap_ok && started_q && enabled_q;
   assign dec      = tick && enabled_q && started_q && !pend_q
                     && (count_q != '0) && !tap_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enabled_q <= 1'b0;
         started_q <= 1'b0;
         irq_en_q  <= 1'b0;
         lock_q    <= 1'b0;
         pend_q    <= 1'b0;
         count_q   <= '0;
         reload_q  <= '0;
      end else begin
         if (dec) begin
            count_q <= count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) pend_q <= 1'b1;
         end
         if (ctrl_ok) begin
            enabled_q <= ctrl_wdata[0];
            irq_en_q  <= ctrl_wdata[2];
            lock_q    <= ctrl_wdata[3];
         end
         if (start_ok) begin
            count_q   <= reload_q;
            started_q <= 1'b1;
            enabled_q <= 1'b1;
         end
         if (reload_we && !lock_q) reload_q <= wdata;
         if (tap_hit) begin
            if (win_bad) begin
               pend_q <= 1'b1;
            end else begin
               count_q <= reload_q;
               pend_q  <= 1'b0;
            end
         end
      end
   end

`ifdef WDT_WINDOW_EN
   logic [CNT_W-1:0] window_q;

   assign win_bad = (window_q != '0) && (count_q > window_q);
   assign window  = window_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         window_q  <= '0;
         violation <= 1'b0;
      end else begin
         if (window_we && !lock_q) window_q <= wdata;
         if (tap_hit) violation <= win_bad;
      end
   end
`else
   logic unused_win;

   assign win_bad    = 1'b0;
   assign violation  = 1'b0;
   assign window     = '0;
   assign unused_win = window_we;
`endif

   assign ctrl    = {lock_q, irq_en_q, started_q, enabled_q};
   assign reload  = reload_q;
   assign count   = count_q;
   assign pending = pend_q;
   assign irq_en  = irq_en_q;
   assign status  = {violation, (count_q != '0), pend_q,
                     started_q, enabled_q};

endmodule

// File: rtl/tqvp_nkanderson_wdt_mc.sv
// tqvp_nkanderson_wdt_mc: multi-channel watchdog with shared prescaler.
// Define WDT_WINDOW_EN to build the windowed-tap check.
module tqvp_nkanderson_wdt_mc
   import tqvp_wdt_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 32,
   parameter int PRE_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              ui_in,
   output logic [7:0]              uo_out,
   tqvp_nkanderson_wdt_mc_if.slave bus,
   output logic                    user_interrupt
);

   logic        wr;
   logic [31:0] wdata;
   logic        tap_ok;
   logic        glb;
   logic [1:0]  ch_sel;
   logic [2:0]  off;

   assign wr     = bus.data_write_n != 2'b11;
   assign wdata  = wr_extend(bus.data_write_n, bus.data_in);
   assign tap_ok = wdata == TAP_MAGIC;
   assign glb    = bus.address[5];
   assign ch_sel = bus.address[4:3];
   assign off    = bus.address[2:0];

   logic [PRE_W-1:0] prescale;
   logic [PRE_W-1:0] pre_cnt;
   logic             tick;

   // A PRESCALE write restarts the phase so the new period applies at once.
   assign tick = pre_cnt >= prescale;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescale <= '0;
         pre_cnt  <= '0;
      end else if (wr && (bus.address == ADDR_PRESCALE)) begin
         prescale <= wdata[PRE_W-1:0];
         pre_cnt  <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   logic [3:0][CNT_W-1:0] reload_a;
   logic [3:0][CNT_W-1:0] window_a;
   logic [3:0][CNT_W-1:0] count_a;
   logic [3:0][3:0]       ctrl_a;
   logic [3:0][4:0]       status_a;
   logic [3:0]            pend_a;
   logic [3:0]            irq_a;

   for (genvar g = 0; g < 4; g++) begin : g_ch
      if (g < NUM_CH) begin : g_on
         logic sel;
         assign sel = wr && !glb && (ch_sel == 2'(g));

         tqvp_wdt_channel #(
            .CNT_W(CNT_W)
         ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .ctrl_we   (sel && (off == OFF_CTRL)),
            .reload_we (sel && (off == OFF_RELOAD)),
            .window_we (sel && (off == OFF_WINDOW)),
            .tap_we    (sel && (off == OFF_TAP)),
            .tap_ok    (tap_ok),
            .ctrl_wdata(wdata[3:0]),
            .wdata     (wdata[CNT_W-1:0]),
            .ctrl      (ctrl_a[g]),
            .reload    (reload_a[g]),
            .window    (window_a[g]),
            .count     (count_a[g]),
            .status    (status_a[g]),
            .pending   (pend_a[g]),
            .irq_en    (irq_a[g])
         );
      end else begin : g_off
         assign ctrl_a[g]   = '0;
         assign reload_a[g] = '0;
         assign window_a[g] = '0;
         assign count_a[g]  = '0;
         assign status_a[g] = '0;
         assign pend_a[g]   = 1'b0;
         assign irq_a[g]    = 1'b0;
      end
   end

   logic [31:0] rd;

   always_comb begin
      rd = RD_UNMAPPED;
      if (glb) begin
         if (bus.address == ADDR_PRESCALE) begin
            rd = '0;
            rd[PRE_W-1:0] = prescale;
         end else if (bus.address == ADDR_IRQ_STATUS) begin
            rd = {28'b0, pend_a};
         end
      end else if (int'(ch_sel) < NUM_CH) begin
         unique case (off)
            OFF_CTRL:   rd = {28'b0, ctrl_a[ch_sel]};
            OFF_RELOAD: begin
               rd = '0;
               rd[CNT_W-1:0] = reload_a[ch_sel];
            end
`ifdef WDT_WINDOW_EN
            OFF_WINDOW: begin
               rd = '0;
               rd[CNT_W-1:0] = window_a[ch_sel];
            end
`endif
            OFF_STATUS: rd = {27'b0, status_a[ch_sel]};
            OFF_COUNT:  begin
               rd = '0;
               rd[CNT_W-1:0] = count_a[ch_sel];
            end
            default:    rd = RD_UNMAPPED;
         endcase
      end
   end

   logic unused_in;
   assign unused_in = ^{ui_in, window_a};

   assign bus.data_out   = rd;
   assign bus.data_ready = (bus.data_read_n != 2'b11) && !rst;
   assign uo_out         = {4'b0, pend_a};
   assign user_interrupt = |(pend_a & irq_a);

endmodule
